// File: rtl/weight_rle_decoder.sv
// Run-length decoder for compressed 3x3 filter-group weights: expands (run, value) entries
// into per-entry kernel coordinates (k, r, c) and value arrays for a downstream address stage.
module weight_rle_decoder #(
    parameter int MAX_NNZ = 16,
    parameter int NUM_K   = 8,
    parameter int VAL_W   = 8,
    parameter int RUN_W   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_valid,
    input  logic [RUN_W-1:0]           i_run,
    input  logic [VAL_W-1:0]           i_val,
    input  logic                       i_last,
    output logic                       o_ready,
    output logic [1:0]                 o_r   [0:MAX_NNZ-1],
    output logic [1:0]                 o_c   [0:MAX_NNZ-1],
    output logic [$clog2(NUM_K)-1:0]   o_k   [0:MAX_NNZ-1],
    output logic [VAL_W-1:0]           o_val [0:MAX_NNZ-1],
    output logic [$clog2(MAX_NNZ):0]   o_length,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int KW = $clog2(NUM_K);
    localparam int IW = $clog2(MAX_NNZ);
    localparam int LW = IW + 1;

    typedef enum logic [1:0] {IDLE, DECODE, SKIP, DONE} state_t;

    state_t            state;
    logic [1:0]        pos_r, pos_c;
    logic [KW-1:0]     pos_k;
    logic              oor;
    logic [RUN_W-1:0]  skip;
    logic [VAL_W-1:0]  lat_val;
    logic              lat_last;

    logic              accept, adv, rec_en, rec_last, drop;
    logic [VAL_W-1:0]  rec_val;
    logic [1:0]        nxt_r, nxt_c;
    logic [KW-1:0]     nxt_k;
    logic              nxt_oor;

    // Recording happens either on a run-0 acceptance or on the last skip cycle of a run.
    always_comb begin
        accept   = (state == DECODE) && i_valid;
        adv      = accept || (state == SKIP);
        rec_en   = (accept && (i_run == '0)) || ((state == SKIP) && (skip == RUN_W'(1)));
        rec_val  = (state == SKIP) ? lat_val  : i_val;
        rec_last = (state == SKIP) ? lat_last : i_last;
        drop     = oor || (o_length == LW'(MAX_NNZ));

        nxt_c   = pos_c;
        nxt_r   = pos_r;
        nxt_k   = pos_k;
        nxt_oor = oor;
        if (!oor) begin
            if (pos_c != 2'd2) begin
                nxt_c = pos_c + 2'd1;
            end else begin
                nxt_c = 2'd0;
                if (pos_r != 2'd2) begin
                    nxt_r = pos_r + 2'd1;
                end else begin
                    nxt_r = 2'd0;
                    if (pos_k == KW'(NUM_K - 1)) nxt_oor = 1'b1;
                    else                         nxt_k   = pos_k + KW'(1);
                end
            end
        end
    end

    // Latched entry payload while its zero run is being skipped.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lat_val  <= i_val;
            lat_last <= i_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            o_ready  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            o_length <= '0;
            pos_r    <= '0;
            pos_c    <= '0;
            pos_k    <= '0;
            oor      <= 1'b0;
            skip     <= '0;
            for (int i = 0; i < MAX_NNZ; i++) begin
                o_r[i]   <= '0;
                o_c[i]   <= '0;
                o_k[i]   <= '0;
                o_val[i] <= '0;
            end
        end else begin
            o_done <= 1'b0;

            if (adv) begin
                pos_c <= nxt_c;
                pos_r <= nxt_r;
                pos_k <= nxt_k;
                oor   <= nxt_oor;
            end

            if (rec_en) begin
                if (drop) begin
                    o_err <= 1'b1;
                end else begin
                    o_r[o_length[IW-1:0]]   <= pos_r;
                    o_c[o_length[IW-1:0]]   <= pos_c;
                    o_k[o_length[IW-1:0]]   <= pos_k;
                    o_val[o_length[IW-1:0]] <= rec_val;
                    o_length                <= o_length + LW'(1);
                end
                if (rec_last) begin
                    state   <= DONE;
                    o_ready <= 1'b0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                end else begin
                    state   <= DECODE;
                    o_ready <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state    <= DECODE;
                        o_ready  <= 1'b1;
                        o_busy   <= 1'b1;
                        o_err    <= 1'b0;
                        o_length <= '0;
                        pos_r    <= '0;
                        pos_c    <= '0;
                        pos_k    <= '0;
                        oor      <= 1'b0;
                    end
                end
                DECODE: begin
                    if (i_valid && (i_run != '0)) begin
                        state   <= SKIP;
                        o_ready <= 1'b0;
                        skip    <= i_run;
                    end
                end
                SKIP: begin
                    skip <= skip - RUN_W'(1);
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_rle_decoder.sv
// Scoreboard bench for weight_rle_decoder: directed groups push expected results,
// a negedge monitor pops and compares them whenever o_done fires.
module tb_weight_rle_decoder;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_start, i_valid, i_last;
    logic [3:0]  i_run;
    logic [7:0]  i_val;
    logic        o_ready, o_busy, o_done, o_err;
    logic [1:0]  o_r   [0:15];
    logic [1:0]  o_c   [0:15];
    logic [2:0]  o_k   [0:15];
    logic [7:0]  o_val [0:15];
    logic [4:0]  o_length;

    weight_rle_decoder #(.MAX_NNZ(16), .NUM_K(8), .VAL_W(8), .RUN_W(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid),
        .i_run(i_run), .i_val(i_val), .i_last(i_last), .o_ready(o_ready),
        .o_r(o_r), .o_c(o_c), .o_k(o_k), .o_val(o_val), .o_length(o_length),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [4:0]        len;
        logic              err;
        logic [7:0]        lat;
        logic [15:0][2:0]  k;
        logic [15:0][1:0]  r;
        logic [15:0][1:0]  c;
        logic [15:0][7:0]  v;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   q_run[$], q_val[$], q_last[$];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0, first_acc = 0, grp = 0;
    bit   armed = 1'b0;

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(int run, int val, int last);
        q_run.push_back(run);
        q_val.push_back(val);
        q_last.push_back(last);
    endtask

    task automatic ent(int idx, int k, int r, int c, int v);
        cur.k[idx] = k[2:0];
        cur.r[idx] = r[1:0];
        cur.c[idx] = c[1:0];
        cur.v[idx] = v[7:0];
    endtask

    task automatic new_group(int len, int err, int lat);
        q_run.delete();
        q_val.delete();
        q_last.delete();
        cur     = '0;
        cur.len = len[4:0];
        cur.err = err[0];
        cur.lat = lat[7:0];
    endtask

    task automatic pulse_start();
        @(posedge i_clk); #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
    endtask

    task automatic drive_entries(int gap, bit start_busy);
        int n;
        for (int i = 0; i < q_run.size(); i++) begin
            if (gap > 0) begin
                if (start_busy && i == 1) begin
                    i_start = 1'b1;
                    @(posedge i_clk); #1 i_start = 1'b0;
                    repeat (gap - 1) @(posedge i_clk);
                    #1;
                end else begin
                    repeat (gap) @(posedge i_clk);
                    #1;
                end
            end
            i_valid = 1'b1;
            i_run   = q_run[i][3:0];
            i_val   = q_val[i][7:0];
            i_last  = q_last[i][0];
            n = 0;
            forever begin
                @(negedge i_clk);
                if (o_ready || n > 300) break;
                n++;
            end
            if (!o_ready) begin
                chk("accept_timeout", o_ready, 1);
                i_valid = 1'b0;
                return;
            end
            @(posedge i_clk); #1 i_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_done && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_done) chk("done_timeout", o_done, 1);
        @(posedge i_clk); #1;
    endtask

    task automatic run_group(int gap, bit start_busy);
        sb.push_back(cur);
        pulse_start();
        drive_entries(gap, start_busy);
        wait_done();
    endtask

    // Monitor: latency is counted from the first accepted entry of each started group.
    always @(negedge i_clk) begin
        exp_t e;
        cyc++;
        if (i_rst_n && i_start && !o_busy && !o_done) armed = 1'b1;
        if (armed && i_valid && o_ready) begin
            first_acc = cyc;
            armed     = 1'b0;
        end
        if (o_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                grp++;
                chk($sformatf("g%0d_length", grp), o_length, e.len);
                chk($sformatf("g%0d_err", grp), o_err, e.err);
                chk($sformatf("g%0d_ready_in_done", grp), o_ready, 0);
                chk($sformatf("g%0d_busy_in_done", grp), o_busy, 0);
                chk($sformatf("g%0d_latency", grp), cyc - first_acc, e.lat);
                for (int i = 0; i < e.len; i++) begin
                    chk($sformatf("g%0d_e%0d_k", grp, i), o_k[i], e.k[i]);
                    chk($sformatf("g%0d_e%0d_r", grp, i), o_r[i], e.r[i]);
                    chk($sformatf("g%0d_e%0d_c", grp, i), o_c[i], e.c[i]);
                    chk($sformatf("g%0d_e%0d_val", grp, i), o_val[i], e.v[i]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_valid = 1'b0;
        i_run = '0; i_val = '0; i_last = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_ready", o_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_length", o_length, 0);
        chk("rst_val0", o_val[0], 0);

        // Three entries with runs 0, 2, 9: positions 0, 3, 13.
        new_group(3, 0, 14);
        add(0, 5, 0); add(2, 7, 0); add(9, 3, 1);
        ent(0, 0, 0, 0, 5); ent(1, 0, 1, 0, 7); ent(2, 1, 1, 1, 3);
        run_group(0, 1'b0);

        // Single entry, done the following cycle.
        new_group(1, 0, 1);
        add(0, 9, 1);
        ent(0, 0, 0, 0, 9);
        run_group(0, 1'b0);

        // 17 dense entries: the 17th overflows the 16-entry store.
        new_group(16, 1, 17);
        for (int i = 0; i < 17; i++) add(0, i + 1, (i == 16) ? 1 : 0);
        for (int i = 0; i < 16; i++) ent(i, i / 9, (i % 9) / 3, i % 3, i + 1);
        run_group(0, 1'b0);

        // Runs of 15 walk past flat position 71; the 5th and final entries are dropped.
        new_group(4, 1, 81);
        for (int i = 0; i < 5; i++) add(15, 1, 0);
        add(0, 2, 1);
        ent(0, 1, 2, 0, 1); ent(1, 3, 1, 1, 1); ent(2, 5, 0, 2, 1); ent(3, 7, 0, 0, 1);
        run_group(0, 1'b0);

        // Reset during the skip phase, then a clean decode.
        new_group(0, 0, 0);
        add(9, 3, 1);
        pulse_start();
        i_valid = 1'b1; i_run = 4'd9; i_val = 8'd3; i_last = 1'b1;
        @(negedge i_clk);
        chk("abort_ready_before_accept", o_ready, 1);
        @(posedge i_clk); #1 i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_ready", o_ready, 0);
        chk("mid_rst_done", o_done, 0);
        chk("mid_rst_err", o_err, 0);
        chk("mid_rst_length", o_length, 0);
        chk("mid_rst_val0", o_val[0], 0);
        chk("mid_rst_k0", o_k[0], 0);
        @(posedge i_clk); #1 i_rst_n = 1'b1;
        new_group(1, 0, 2);
        add(1, 4, 1);
        ent(0, 0, 0, 1, 4);
        run_group(0, 1'b0);

        // Same as the first group with 3-cycle valid gaps and a stray start while busy.
        new_group(3, 0, 18);
        add(0, 5, 0); add(2, 7, 0); add(9, 3, 1);
        ent(0, 0, 0, 0, 5); ent(1, 0, 1, 0, 7); ent(2, 1, 1, 1, 3);
        run_group(3, 1'b1);

        repeat (5) @(posedge i_clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
